fetch_unit: RTL and testbench

Instruction-fetch front end of the 5-stage pipeline: owns the fetch PC, issues one-outstanding requests to instruction memory, and drives the IF/ID pipeline register consumed by decode and hazard detection. It sits directly upstream of the ID stage. It obeys `stall`, `flush_IFID` and `BranchTaken` from the hazard detection unit, and `branch_target` from ID-stage branch resolution. A one-entry holding buffer absorbs memory responses that arrive while ID is stalled.

---
 rtl/fetch_unit_pkg.sv | 11 +
 rtl/fetch_unit_if.sv | 12 +
 rtl/fetch_unit_if_id_reg.sv | 42 ++++
 rtl/fetch_unit.sv | 118 +++++++++++
 tb/tb_fetch_unit.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared CPU definitions for the instruction-fetch front end.
package cpu_pkg;
  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP
  } fetch_state_t;
endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between fetch and imem.
interface fetch_unit_if;
  import cpu_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_rvalid, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_rvalid, imem_rdata);
endinterface

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: reset, bubble, stall-hold, then load-or-bubble.
module if_id_reg import cpu_pkg::*; (
  input  logic            clk,
  input  logic            rst,
  input  logic            bubble_i,
  input  logic            stall_i,
  input  logic            load_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] inst_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] inst_o,
  output logic            valid_o
);
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] inst_q;
  logic            valid_q;

  // A bubble keeps the previous PC so ID always sees a meaningful address.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= '0;
      inst_q  <= NOP_INST;
      valid_q <= 1'b0;
    end else if (bubble_i) begin
      inst_q  <= NOP_INST;
      valid_q <= 1'b0;
    end else if (!stall_i) begin
      if (load_i) begin
        pc_q    <= pc_i;
        inst_q  <= inst_i;
        valid_q <= 1'b1;
      end else begin
        inst_q  <= NOP_INST;
        valid_q <= 1'b0;
      end
    end
  end

  assign pc_o    = pc_q;
  assign inst_o  = inst_q;
  assign valid_o = valid_q;
endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: owns pc_f, keeps one imem request in flight, and feeds
// IF/ID through a one-entry buffer that absorbs responses arriving under stall.
module fetch_unit import cpu_pkg::*; #(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush_IFID,
  input  logic              BranchTaken,
  input  logic [XLEN-1:0]   branch_target,
  fetch_unit_if.master      imem,
  output logic [XLEN-1:0]   PC_ID,
  output logic [XLEN-1:0]   inst_ID,
  output logic              valid_ID
);
  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_f_q, pc_f_d;
  logic            buf_valid_q, buf_valid_d;
  logic [XLEN-1:0] buf_pc_q, buf_pc_d;
  logic [XLEN-1:0] buf_inst_q, buf_inst_d;
  logic            req;
  logic [XLEN-1:0] addr;
  logic            redirect;
  logic            resp;

  assign redirect = BranchTaken && !stall;
  assign resp     = imem.imem_rvalid;

  always_comb begin
    state_d     = state_q;
    pc_f_d      = pc_f_q;
    buf_valid_d = buf_valid_q;
    buf_pc_d    = buf_pc_q;
    buf_inst_d  = buf_inst_q;
    req         = 1'b0;
    addr        = pc_f_q;
    unique case (state_q)
      IDLE: begin
        if (redirect) begin
          req     = 1'b1;
          addr    = branch_target;
          pc_f_d  = branch_target;
          state_d = WAIT;
        end else if (!buf_valid_q) begin
          req     = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (resp) begin
          if (redirect) begin
            req    = 1'b1;
            addr   = branch_target;
            pc_f_d = branch_target;
          end else if (!stall) begin
            req    = 1'b1;
            addr   = pc_f_q + 32'd4;
            pc_f_d = pc_f_q + 32'd4;
          end else begin
            buf_valid_d = 1'b1;
            buf_pc_d    = pc_f_q;
            buf_inst_d  = imem.imem_rdata;
            pc_f_d      = pc_f_q + 32'd4;
            state_d     = IDLE;
          end
        end else if (redirect) begin
          pc_f_d  = branch_target;
          state_d = DROP;
        end
      end
      DROP: begin
        if (redirect) pc_f_d = branch_target;
        if (resp) begin
          req     = 1'b1;
          addr    = redirect ? branch_target : pc_f_q;
          state_d = WAIT;
        end
      end
      default: state_d = IDLE;
    endcase
    // The buffer drains into IF/ID only when IF/ID is neither held nor flushed.
    if (redirect) buf_valid_d = 1'b0;
    else if (buf_valid_q && !stall && !flush_IFID) buf_valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_f_q      <= RESET_PC;
      buf_valid_q <= 1'b0;
      buf_pc_q    <= '0;
      buf_inst_q  <= '0;
    end else begin
      state_q     <= state_d;
      pc_f_q      <= pc_f_d;
      buf_valid_q <= buf_valid_d;
      buf_pc_q    <= buf_pc_d;
      buf_inst_q  <= buf_inst_d;
    end
  end

  assign imem.imem_req  = req && !rst;
  assign imem.imem_addr = addr;

  if_id_reg u_if_id (
    .clk      (clk),
    .rst      (rst),
    .bubble_i (redirect || (flush_IFID && !stall)),
    .stall_i  (stall),
    .load_i   (buf_valid_q || (state_q == WAIT && resp)),
    .pc_i     (buf_valid_q ? buf_pc_q : pc_f_q),
    .inst_i   (buf_valid_q ? buf_inst_q : imem.imem_rdata),
    .pc_o     (PC_ID),
    .inst_o   (inst_ID),
    .valid_o  (valid_ID)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed timing scenarios plus random stall/branch
// traffic checked against a program-order model of what must reach ID.
module tb_fetch_unit;
  import cpu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, flush_IFID, BranchTaken;
  logic [31:0] branch_target;
  logic [31:0] PC_ID, inst_ID;
  logic        valid_ID;
  logic [31:0] w_pc, w_inst;
  logic        w_valid;

  fetch_unit_if imem_bus ();
  fetch_unit_if wbus ();

  fetch_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .flush_IFID(flush_IFID),
    .BranchTaken(BranchTaken), .branch_target(branch_target), .imem(imem_bus),
    .PC_ID(PC_ID), .inst_ID(inst_ID), .valid_ID(valid_ID)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .rst(rst), .stall(1'b0), .flush_IFID(1'b0),
    .BranchTaken(1'b0), .branch_target(32'h0), .imem(wbus),
    .PC_ID(w_pc), .inst_ID(w_inst), .valid_ID(w_valid)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Memory: in-order, returns addr+0x100 after a fixed or random latency.
  int unsigned lat_fixed = 1;
  bit          lat_rand  = 1'b0;
  bit          m_pend = 1'b0, m_nxt = 1'b0;
  int unsigned m_cnt = 0;
  logic [31:0] m_paddr = '0;

  always @(negedge clk) begin
    if (rst) begin
      m_pend = 1'b0;
      m_nxt  = 1'b0;
    end else begin
      if (imem_bus.imem_rvalid) m_pend = 1'b0;
      if (imem_bus.imem_req) begin
        chk("one_outstanding", 32'(m_pend), 32'd0);
        m_pend  = 1'b1;
        m_paddr = imem_bus.imem_addr;
        m_cnt   = lat_rand ? $urandom_range(1, 3) : lat_fixed;
      end
      m_nxt = 1'b0;
      if (m_pend && m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) m_nxt = 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    #2;
    imem_bus.imem_rvalid = m_nxt;
    imem_bus.imem_rdata  = m_nxt ? m_paddr + 32'h100 : 32'hDEAD_BEEF;
  end

  // Second memory (1-cycle) for the wrap-around instance.
  bit          w_nxt = 1'b0;
  logic [31:0] w_naddr = '0;
  always @(negedge clk) begin
    w_nxt   = !rst && wbus.imem_req;
    w_naddr = wbus.imem_addr;
  end
  always @(posedge clk) begin
    #2;
    wbus.imem_rvalid = w_nxt;
    wbus.imem_rdata  = w_naddr + 32'h100;
  end

  // Program-order model of ID: sequential PCs, restart at target after a redirect.
  bit          sb_armed = 1'b0, sb_sync = 1'b0;
  logic        p_rst = 1'b0, p_stall = 1'b0, p_redir = 1'b0, p_flush = 1'b0;
  logic [31:0] p_tgt = '0, exp_pc = '0, l_pc = '0, l_inst = '0;
  logic        l_valid = 1'b0;
  int unsigned deliveries = 0;

  always @(negedge clk) begin
    if (sb_armed) begin
      if (p_rst) begin
        chk("rst_valid", 32'(valid_ID), 32'd0);
        chk("rst_inst", inst_ID, NOP_INST);
        chk("rst_pc", PC_ID, 32'h0);
        exp_pc  = 32'h0;
        sb_sync = 1'b1;
      end else if (p_redir || (p_flush && !p_stall)) begin
        chk("bubble_valid", 32'(valid_ID), 32'd0);
        chk("bubble_inst", inst_ID, NOP_INST);
        chk("bubble_pc", PC_ID, l_pc);
        if (p_redir) begin
          exp_pc  = p_tgt;
          sb_sync = 1'b1;
        end else begin
          sb_sync = 1'b0;
        end
      end else if (p_stall) begin
        chk("hold_pc", PC_ID, l_pc);
        chk("hold_inst", inst_ID, l_inst);
        chk("hold_valid", 32'(valid_ID), 32'(l_valid));
      end else if (valid_ID) begin
        if (sb_sync) chk("order_pc", PC_ID, exp_pc);
        chk("inst_data", inst_ID, PC_ID + 32'h100);
        exp_pc  = PC_ID + 32'd4;
        sb_sync = 1'b1;
        deliveries++;
      end else begin
        chk("empty_pc", PC_ID, l_pc);
        chk("empty_inst", inst_ID, NOP_INST);
      end
    end
    if (rst) sb_armed = 1'b1;
    p_rst   = rst;
    p_stall = stall;
    p_redir = BranchTaken && !stall;
    p_flush = flush_IFID;
    p_tgt   = branch_target;
    l_pc    = PC_ID;
    l_inst  = inst_ID;
    l_valid = valid_ID;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic s, input logic b, input logic f, input logic [31:0] t);
    stall = s; BranchTaken = b; flush_IFID = f; branch_target = t;
  endtask

  task automatic step(input logic s, input logic b, input logic f, input logic [31:0] t);
    tick();
    drive(s, b, f, t);
    @(negedge clk);
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  // Leaves the bench at the negedge of cycle 0 (first cycle out of reset).
  task automatic do_reset();
    tick();
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    @(negedge clk);
    chk("rst_req", 32'(imem_bus.imem_req), 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk_req(input string tag, input logic [31:0] a);
    chk({tag, "_req"}, 32'(imem_bus.imem_req), 32'd1);
    chk({tag, "_addr"}, imem_bus.imem_addr, a);
  endtask

  task automatic chk_id(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] inst);
    chk({tag, "_valid"}, 32'(valid_ID), 32'(v));
    chk({tag, "_pc"}, PC_ID, pc);
    chk({tag, "_inst"}, inst_ID, inst);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0);

    // Reset release, straight-line fetch, and wrap-around on the second instance.
    lat_fixed = 1; lat_rand = 1'b0;
    do_reset();
    chk_req("t1_c0", 32'h0);
    chk("wrap_addr0", wbus.imem_addr, 32'hFFFF_FFF8);
    idle_step();
    chk_req("t1_c1", 32'h4);
    idle_step();
    chk_id("t1_c2", 1'b1, 32'h0, 32'h100);
    chk("wrap_pc0", w_pc, 32'hFFFF_FFF8);
    chk("wrap_inst0", w_inst, 32'hFFFF_FFF8 + 32'h100);
    idle_step();
    chk_id("t1_c3", 1'b1, 32'h4, 32'h104);
    chk("wrap_pc1", w_pc, 32'hFFFF_FFFC);
    idle_step();
    chk_id("t1_c4", 1'b1, 32'h8, 32'h108);
    chk("wrap_pc2", w_pc, 32'h0);
    chk("wrap_valid2", 32'(w_valid), 32'd1);

    // Stall for three cycles while the response for 0x8 arrives.
    do_reset();
    idle_step();
    idle_step();
    for (int c = 3; c <= 5; c++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0);
      chk("t2_noreq", 32'(imem_bus.imem_req), 32'd0);
      chk_id("t2_hold", 1'b1, 32'h4, 32'h104);
    end
    idle_step();
    chk("t2_c6_noreq", 32'(imem_bus.imem_req), 32'd0);
    chk_id("t2_c6", 1'b1, 32'h4, 32'h104);
    idle_step();
    chk_id("t2_c7", 1'b1, 32'h8, 32'h108);
    chk_req("t2_c7", 32'hC);
    idle_step();
    idle_step();
    chk_id("t2_c9", 1'b1, 32'hC, 32'h10C);

    // Reset while the holding buffer is full.
    do_reset();
    idle_step();
    idle_step();
    step(1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk_id("t6a_rst", 1'b0, 32'h0, NOP_INST);
    chk_req("t6a_first", 32'h0);
    idle_step();
    idle_step();
    chk_id("t6a_c7", 1'b1, 32'h0, 32'h100);

    // Reset while a 3-cycle request is outstanding.
    lat_fixed = 3;
    do_reset();
    chk_req("t6b_c0", 32'h0);
    tick();
    rst = 1'b1;
    @(negedge clk);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk_req("t6b_first", 32'h0);
    chk("t6b_valid", 32'(valid_ID), 32'd0);
    for (int c = 3; c <= 5; c++) begin
      idle_step();
      chk("t6b_wait_valid", 32'(valid_ID), 32'd0);
    end
    idle_step();
    chk_id("t6b_c6", 1'b1, 32'h0, 32'h100);

    // Redirect to 0x40 while a 3-cycle request is in flight.
    do_reset();
    chk_req("t3_c0", 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h40);
    chk("t3_c1_noreq", 32'(imem_bus.imem_req), 32'd0);
    idle_step();
    chk("t3_c2_noreq", 32'(imem_bus.imem_req), 32'd0);
    chk("t3_c2_valid", 32'(valid_ID), 32'd0);
    idle_step();
    chk_req("t3_c3", 32'h40);
    for (int c = 4; c <= 6; c++) begin
      idle_step();
      chk("t3_squash_valid", 32'(valid_ID), 32'd0);
    end
    idle_step();
    chk_id("t3_c7", 1'b1, 32'h40, 32'h140);

    // BranchTaken ignored under stall, honoured the next cycle.
    lat_fixed = 1;
    do_reset();
    idle_step();
    idle_step();
    step(1'b1, 1'b1, 1'b0, 32'h80);
    chk("t4_c3_noreq", 32'(imem_bus.imem_req), 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'h80);
    chk_req("t4_c4", 32'h80);
    chk_id("t4_c4", 1'b1, 32'h4, 32'h104);
    idle_step();
    chk_id("t4_c5", 1'b0, 32'h4, NOP_INST);
    idle_step();
    chk_id("t4_c6", 1'b1, 32'h80, 32'h180);
    idle_step();
    chk_id("t4_c7", 1'b1, 32'h84, 32'h184);

    // Flush alone bubbles; flush under stall is ignored.
    do_reset();
    idle_step();
    idle_step();
    step(1'b0, 1'b0, 1'b1, 32'h0);
    chk_id("t5_c3", 1'b1, 32'h4, 32'h104);
    idle_step();
    chk_id("t5_c4", 1'b0, 32'h4, NOP_INST);
    step(1'b1, 1'b0, 1'b1, 32'h0);
    chk_id("t5_c5", 1'b1, 32'hC, 32'h10C);
    idle_step();
    chk_id("t5_c6", 1'b1, 32'hC, 32'h10C);
    idle_step();
    chk_id("t5_c7", 1'b1, 32'h10, 32'h110);

    // Random stalls, branches and latencies against the program-order model.
    lat_rand = 1'b1;
    do_reset();
    deliveries = 0;
    for (int i = 0; i < 2000; i++) begin
      logic        s, b, f;
      logic [31:0] t;
      s = ($urandom % 10) < 3;
      b = ($urandom % 10) == 0;
      t = $urandom & 32'hFFFF_FFFC;
      if (($urandom % 4) == 0) t = 32'hFFFF_FFF0 | (t & 32'hC);
      f = b | (s & $urandom % 2);
      step(s, b, f, t);
    end
    chk("rand_progress", 32'(deliveries > 200), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
